cpu_mem_arbiter: RTL

Two-client memory arbiter that sits directly downstream of the multi-cycle `custom_cpu`. It merges the CPU's instruction fetch channel and its data load/store channel onto a single memory request/response port. It serialises the two clients with round-robin priority, allows one transaction in flight at a time, and routes each read response back to the client that issued it. It also provides a contention counter, which the CPU can expose as a performance counter.

---
 rtl/cpu_mem_pkg.sv | 33 +++
 rtl/rr_arbiter2.sv | 45 ++++
 rtl/cpu_mem_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/cpu_mem_pkg.sv
// ----------------------------------------------------------------------------
// cpu_mem_pkg : shared widths, state encoding and grant indices for the arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package cpu_mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [4:0] S_IDLE_OH  = 5'b00001;
  localparam logic [4:0] S_IREQ_OH  = 5'b00010;
  localparam logic [4:0] S_IRESP_OH = 5'b00100;
  localparam logic [4:0] S_DREQ_OH  = 5'b01000;
  localparam logic [4:0] S_DRESP_OH = 5'b10000;

  typedef enum logic [4:0] {
    ST_IDLE  = S_IDLE_OH,
    ST_IREQ  = S_IREQ_OH,
    ST_IRESP = S_IRESP_OH,
    ST_DREQ  = S_DREQ_OH,
    ST_DRESP = S_DRESP_OH
  } state_t;

  // Bit positions inside the two-bit request/grant vectors.
  localparam int GNT_I = 0;
  localparam int GNT_D = 1;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ----------------------------------------------------------------------------
// rr_arbiter2 : two-way round-robin arbiter, remembers the last granted client
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter2
  import cpu_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt
);

  logic last_d_q;
  logic last_d_d;

  // On a tie, hand the port to whichever client did not have it last.
  always_comb begin
    gnt = 2'b00;
    if (req[GNT_I] && req[GNT_D]) begin
      if (last_d_q) gnt[GNT_I] = 1'b1;
      else          gnt[GNT_D] = 1'b1;
    end else if (req[GNT_I]) begin
      gnt[GNT_I] = 1'b1;
    end else if (req[GNT_D]) begin
      gnt[GNT_D] = 1'b1;
    end
  end

  always_comb begin
    last_d_d = last_d_q;
    if (upd && (gnt != 2'b00)) last_d_d = gnt[GNT_D];
  end

  always_ff @(posedge clk) begin
    if (rst) last_d_q <= 1'b1;
    else     last_d_q <= last_d_d;
  end

endmodule

`default_nettype wire

// File: rtl/cpu_mem_arbiter.sv
// ----------------------------------------------------------------------------
// cpu_mem_arbiter : merges CPU fetch and load/store channels onto one memory port
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cpu_mem_arbiter
  import cpu_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] PC,
  input  logic              Inst_Req_Valid,
  output logic              Inst_Req_Ready,
  output logic [DATA_W-1:0] Instruction,
  output logic              Inst_Valid,
  input  logic              Inst_Ready,
  input  logic [ADDR_W-1:0] Address,
  input  logic              MemWrite,
  input  logic [DATA_W-1:0] Write_data,
  input  logic [STRB_W-1:0] Write_strb,
  input  logic              MemRead,
  output logic              Mem_Req_Ready,
  output logic [DATA_W-1:0] Read_data,
  output logic              Read_data_Valid,
  input  logic              Read_data_Ready,
  output logic              m_req_valid,
  input  logic              m_req_ready,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_wen,
  output logic [DATA_W-1:0] m_wdata,
  output logic [STRB_W-1:0] m_wstrb,
  input  logic              m_resp_valid,
  output logic              m_resp_ready,
  input  logic [DATA_W-1:0] m_rdata,
  output logic [31:0]       arb_wait_cnt
);

  state_t      state_q, state_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic        w_inst_pend;
  logic        w_data_pend;
  logic [1:0]  w_req;
  logic [1:0]  w_gnt;
  logic        w_upd;

  assign w_inst_pend = Inst_Req_Valid;
  assign w_data_pend = MemRead | MemWrite;

  always_comb begin
    w_req        = 2'b00;
    w_req[GNT_I] = w_inst_pend;
    w_req[GNT_D] = w_data_pend;
  end

  rr_arbiter2 u_rr (
    .clk (clk),
    .rst (rst),
    .req (w_req),
    .upd (w_upd),
    .gnt (w_gnt)
  );

  always_comb begin
    state_d = state_q;
    w_upd   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_req != 2'b00) begin
          w_upd   = 1'b1;
          state_d = w_gnt[GNT_I] ? ST_IREQ : ST_DREQ;
        end
      end
      ST_IREQ:  if (m_req_ready) state_d = ST_IRESP;
      // Writes carry no response, so the port frees right after the handshake.
      ST_DREQ:  if (m_req_ready) state_d = MemWrite ? ST_IDLE : ST_DRESP;
      ST_IRESP: if (m_resp_valid && Inst_Ready) state_d = ST_IDLE;
      ST_DRESP: if (m_resp_valid && Read_data_Ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if ((w_inst_pend && (state_q != ST_IREQ)) || (w_data_pend && (state_q != ST_DREQ)))
      wait_cnt_d = wait_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    m_req_valid     = 1'b0;
    m_addr          = '0;
    m_wen           = 1'b0;
    m_wdata         = '0;
    m_wstrb         = '0;
    m_resp_ready    = 1'b0;
    Inst_Req_Ready  = 1'b0;
    Mem_Req_Ready   = 1'b0;
    Inst_Valid      = 1'b0;
    Read_data_Valid = 1'b0;
    case (state_q)
      ST_IREQ: begin
        m_req_valid    = 1'b1;
        m_addr         = PC;
        Inst_Req_Ready = m_req_ready;
      end
      ST_DREQ: begin
        m_req_valid   = 1'b1;
        m_addr        = Address;
        m_wen         = MemWrite;
        m_wdata       = Write_data;
        m_wstrb       = MemWrite ? Write_strb : '0;
        Mem_Req_Ready = m_req_ready;
      end
      ST_IRESP: begin
        Inst_Valid   = m_resp_valid;
        m_resp_ready = Inst_Ready;
      end
      ST_DRESP: begin
        Read_data_Valid = m_resp_valid;
        m_resp_ready    = Read_data_Ready;
      end
      default: ;
    endcase
  end

  assign Instruction  = m_rdata;
  assign Read_data    = m_rdata;
  assign arb_wait_cnt = wait_cnt_q;

endmodule

`default_nettype wire
